tl_get_responder: RTL
=====================

# tl_get_responder

TileLink-UL responder that serves the instruction-fetch refill path: it accepts Get requests on channel A and returns multi-beat AccessAckData on channel D from an internal synchronous-read memory. It sits at the far end of the ICache refill port, as the boot ROM/scratchpad for bring-up or as a stand-in for the L2 in unit benches. A preload write port fills the memory before or between transactions.

## Interface
- DATA_BITS, 128, D-channel beat width; beat size 16 B.
- ADDR_BITS, 32, A-channel address width (= `paddrBits`).
- MEM_WORDS, 1024, memory depth in 128-bit words; power of two; the base address is 0.
- MAX_LG_SIZE, 6, largest accepted lgSize (64 B block = 4 beats).
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- a_valid / a_ready  in / out  1  A-channel handshake.
- a_bits_opcode  in  3  Get = 4; any other value is unsupported.
- a_bits_size  in  4  lgSize of the transfer.
- a_bits_source  in  4  source id, echoed on D.
- a_bits_address  in  ADDR_BITS  byte address, aligned to 2^size.
- d_valid / d_ready  out / in  1  D-channel handshake.
- d_bits_opcode  out  3  AccessAckData = 1, or AccessAck = 0.
- d_bits_size  out  4  echoed a_bits_size.
- d_bits_source  out  4  echoed source.
- d_bits_denied  out  1  the request was rejected.
- d_bits_data  out  DATA_BITS  beat payload.
- pre_we  in  1  preload write enable.
- pre_addr  in  log2(MEM_WORDS)  word index.
- pre_wdata  in  DATA_BITS  preload data.

## Operation
- FSM states: IDLE, FETCH, BEAT.
- a_ready = (state==IDLE) && !pre_we.
- On A fire, the block latches opcode, size, source, and address, then goes to FETCH.
- Request classes:
  - Get, size ≤ MAX_LG_SIZE, word index < MEM_WORDS: normal read.
  - Get with size > MAX_LG_SIZE or out of range: denied=1, data=0. The beat count still follows size, clamped to MAX_LG_SIZE.
  - Non-Get: one beat, opcode AccessAck, denied=1.
- Beat count = size ≤ 4 ? 1 : 2^(size-4).
- First word index = address[log2(MEM_WORDS)+3:4], aligned down to the beat count. Beats are sequential with no wrap, and beat counter bits are OR'd into the low index bits.
- Sub-beat sizes (< 4) return the full aligned 128-bit word.
- FETCH issues the read of beat 0 and moves to BEAT.
- BEAT:
  - d_valid=1.
  - On d fire of a non-last beat, the next word is read in the same cycle and the beat counter increments.
  - On d fire of the last beat, go to IDLE.
- A capture register holds d_bits_data stable while d_valid && !d_ready.
- pre_we has priority on the memory port only in IDLE. pre_we outside IDLE is ignored and counted as a protocol error (debug only, not a port).

## Timing
- Reset values:
  - a_ready=1.
  - d_valid=0, d_bits_*=0.
  - State is IDLE and the beat counter is 0.
  - Memory contents are not reset.
- Cycle 0: A fires. Cycle 1: FETCH, read issued. Cycle 2: d_valid=1 with beat 0.
- With d_ready held at 1, beats follow on consecutive cycles: a 4-beat Get occupies cycles 2–5.
- a_ready returns to 1 in the cycle after the last D fire. The minimum request-to-request spacing is beats+2 cycles.
- d_valid, once high, does not drop until fire. The D fields never change while stalled.
- A reset assertion mid-burst aborts immediately. d_valid drops asynchronously and there is no partial-burst completion.
- If a preload and an A request arrive in the same IDLE cycle, the preload wins and a_ready=0 that cycle.
- A preload to the word being read in the same cycle returns old data (read-before-write).

## Structure
- Shared package `TLResponderST` holds:
  - opcode constants (Get=4, AccessAck=0, AccessAckData=1);
  - the FSM state enum;
  - the A-request latch struct;
  - a `beats(lgSize)` function.
- Reuse `BundleST::TLBundleAST` and `TLBundleDST` field widths so the block plugs into `DecoupledIF` wrappers.
- One sub-module: `SyncReadMemNoVec` (DEEPTH=MEM_WORDS, DATA_WIDTH=DATA_BITS) for storage. The FSM, counter, and capture register live in the top.

## Test plan
- Preload words 0x10–0x13 with distinct patterns, then send Get addr 0x100, size 6, source 3, d_ready=1:
  - 4 beats on cycles 2–5 in index order;
  - source 3, size 6, denied 0;
  - a_ready high on cycle 6.
- Same Get with d_ready toggled 1-0-0-1-1-0-1: each beat is held stable while stalled, there are no duplicated or skipped beats, and the sequence completes after the 4th fire.
- Get size 2 at addr 0x104: a single beat containing the full word at index 0x10.
- Get addr beyond MEM_WORDS×16 with size 6: 4 beats, denied=1, data 0. A PutFull opcode 0 returns one AccessAck beat with denied=1.
- Assert reset (0) during beat 2 of a burst: d_valid is 0 at once. After release, a_ready=1 and a fresh Get returns correct data.
- pre_we and a_valid in the same IDLE cycle: a_ready=0. The request is accepted the next cycle and returns the newly written word.

Source files
------------

// File: rtl/tl_get_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tl_get_responder_pkg
// Brief    : Shared opcodes, bundle field widths, FSM state and A-request latch
// Revision : 1.0
// ============================================================================
package tl_get_responder_pkg;

    localparam int c_tl_opcode_bits = 3;
    localparam int c_tl_size_bits   = 4;
    localparam int c_tl_source_bits = 4;

    localparam logic [2:0] c_op_get             = 3'd4;
    localparam logic [2:0] c_op_access_ack      = 3'd0;
    localparam logic [2:0] c_op_access_ack_data = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_BEAT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [c_tl_opcode_bits-1:0] opcode;
        logic [c_tl_size_bits-1:0]   size;
        logic [c_tl_source_bits-1:0] source;
        logic                        is_get;
        logic                        denied;
    } a_req_t;

    // One 16-byte beat per 2^4 bytes; anything smaller still takes one beat.
    function automatic logic [15:0] beats(input logic [3:0] lg_size);
        return (lg_size <= 4'd4) ? 16'd1 : (16'd1 << (lg_size - 4'd4));
    endfunction

endpackage
`default_nettype wire

// File: rtl/tl_get_responder_mem.sv
`default_nettype none
// ============================================================================
// Module   : SyncReadMemNoVec
// Brief    : Synchronous-read memory, one read and one write port, old data on
//            a same-address read/write collision. Contents are not reset.
// Revision : 1.0
// ============================================================================
module SyncReadMemNoVec #(
    parameter int DEEPTH     = 1024,
    parameter int DATA_WIDTH = 128,
    localparam int AW        = $clog2(DEEPTH)
) (
    input  logic                  clock,
    input  logic                  i_ren,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata,
    input  logic                  i_wen,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEEPTH];

    always_ff @(posedge clock) begin
        if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_ren) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/tl_get_responder.sv
`default_nettype none
// ============================================================================
// Module   : tl_get_responder
// Brief    : TileLink-UL Get responder returning multi-beat AccessAckData from
//            an internal preloadable memory.
// Revision : 1.0
// ============================================================================
module tl_get_responder
    import tl_get_responder_pkg::*;
#(
    parameter int DATA_BITS   = 128,
    parameter int ADDR_BITS   = 32,
    parameter int MEM_WORDS   = 1024,
    parameter int MAX_LG_SIZE = 6,
    localparam int IDX_W      = $clog2(MEM_WORDS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [2:0]            a_bits_opcode,
    input  logic [3:0]            a_bits_size,
    input  logic [3:0]            a_bits_source,
    input  logic [ADDR_BITS-1:0]  a_bits_address,
    output logic                  d_valid,
    input  logic                  d_ready,
    output logic [2:0]            d_bits_opcode,
    output logic [3:0]            d_bits_size,
    output logic [3:0]            d_bits_source,
    output logic                  d_bits_denied,
    output logic [DATA_BITS-1:0]  d_bits_data,
    input  logic                  pre_we,
    input  logic [IDX_W-1:0]      pre_addr,
    input  logic [DATA_BITS-1:0]  pre_wdata
);

    localparam logic [3:0] c_max_lg = 4'(MAX_LG_SIZE);

    state_t                r_state;
    a_req_t                r_req;
    logic [IDX_W-1:0]      r_base;
    logic [IDX_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_last;
    logic                  r_fresh;
    logic [DATA_BITS-1:0]  r_cap;
    logic                  r_d_valid;
    logic [2:0]            r_d_opcode;
    logic [3:0]            r_d_size;
    logic [3:0]            r_d_source;
    logic                  r_d_denied;
    logic [15:0]           r_pre_we_err_cnt;

    logic                  w_a_fire;
    logic                  w_d_fire;
    logic                  w_is_last;
    logic                  w_is_get;
    logic                  w_size_ok;
    logic                  w_in_range;
    logic                  w_denied;
    logic [3:0]            w_size_clamp;
    logic [15:0]           w_nbeats;
    logic [IDX_W-1:0]      w_last;
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      w_cnt_next;
    logic                  w_ren;
    logic [IDX_W-1:0]      w_raddr;
    logic                  w_wen;
    logic [DATA_BITS-1:0]  w_mem_rdata;

    assign a_ready   = (r_state == ST_IDLE) && !pre_we;
    assign w_a_fire  = a_valid && a_ready;
    assign w_d_fire  = r_d_valid && d_ready;
    assign w_is_last = (r_cnt == r_last);

    // Request classification on the live A fields.
    assign w_is_get     = (a_bits_opcode == c_op_get);
    assign w_size_ok    = (a_bits_size <= c_max_lg);
    assign w_in_range   = ((a_bits_address >> (IDX_W + 4)) == '0);
    assign w_denied     = !w_is_get || !w_size_ok || !w_in_range;
    assign w_size_clamp = w_size_ok ? a_bits_size : c_max_lg;
    assign w_nbeats     = w_is_get ? beats(w_size_clamp) : 16'd1;
    assign w_last       = IDX_W'(w_nbeats - 16'd1);
    assign w_idx        = a_bits_address[IDX_W+3:4];

    assign w_cnt_next = r_cnt + IDX_W'(1);
    assign w_ren      = (r_state == ST_FETCH) ||
                        ((r_state == ST_BEAT) && w_d_fire && !w_is_last);
    assign w_raddr    = (r_state == ST_FETCH) ? r_base : (r_base | w_cnt_next);
    assign w_wen      = pre_we && (r_state == ST_IDLE);

    SyncReadMemNoVec #(
        .DEEPTH     (MEM_WORDS),
        .DATA_WIDTH (DATA_BITS)
    ) u_mem (
        .clock   (clock),
        .i_ren   (w_ren),
        .i_raddr (w_raddr),
        .o_rdata (w_mem_rdata),
        .i_wen   (w_wen),
        .i_waddr (pre_addr),
        .i_wdata (pre_wdata)
    );

    // Fresh read data is shown directly in its first cycle, then from the capture.
    assign d_valid       = r_d_valid;
    assign d_bits_opcode = r_d_opcode;
    assign d_bits_size   = r_d_size;
    assign d_bits_source = r_d_source;
    assign d_bits_denied = r_d_denied;
    assign d_bits_data   = r_d_denied ? '0 : (r_fresh ? w_mem_rdata : r_cap);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state          <= ST_IDLE;
            r_req            <= '0;
            r_base           <= '0;
            r_cnt            <= '0;
            r_last           <= '0;
            r_fresh          <= 1'b0;
            r_cap            <= '0;
            r_d_valid        <= 1'b0;
            r_d_opcode       <= '0;
            r_d_size         <= '0;
            r_d_source       <= '0;
            r_d_denied       <= 1'b0;
            r_pre_we_err_cnt <= '0;
        end else begin
            r_fresh <= w_ren;
            if (r_fresh) begin
                r_cap <= w_mem_rdata;
            end
            if (pre_we && (r_state != ST_IDLE)) begin
                r_pre_we_err_cnt <= r_pre_we_err_cnt + 16'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_a_fire) begin
                        r_req   <= '{opcode: a_bits_opcode, size: a_bits_size,
                                     source: a_bits_source, is_get: w_is_get,
                                     denied: w_denied};
                        r_base  <= w_idx & ~w_last;
                        r_last  <= w_last;
                        r_cnt   <= '0;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_d_valid  <= 1'b1;
                    r_d_opcode <= r_req.is_get ? c_op_access_ack_data : c_op_access_ack;
                    r_d_size   <= r_req.size;
                    r_d_source <= r_req.source;
                    r_d_denied <= r_req.denied;
                    r_state    <= ST_BEAT;
                end
                ST_BEAT: begin
                    if (w_d_fire) begin
                        if (w_is_last) begin
                            r_d_valid <= 1'b0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_cnt <= w_cnt_next;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
